key_repeat: RTL and testbench
=============================

// Module: key_repeat
// PURPOSE
//  Front-end conditioner for one clock-setting push-button (set/add/beep). Synchronises and debounces the
//  raw pin, then emits single-cycle, clk-domain strobes: one on press, auto-repeat strobes while held, one on release.
//  Feeds the clock control FSM and time counters so "add" can be held to fast-advance hours/minutes/seconds.
//  Fully synchronous to clk; all outputs registered; no derived/gated clocks.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000   clk cycles input must stay changed before stable state flips (20 ms @50 MHz); >=2
//  HOLD_CYCLES      25_000_000  cycles from press_pulse to first auto-repeat (0.5 s); >=2
//  REPEAT_CYCLES    5_000_000   cycles between successive auto-repeat strobes (100 ms); >=2
//  ACTIVE_LOW       1           1: pin reads 0 when pressed; 0: pin reads 1 when pressed
// PORTS
//  clk           in   1  system clock, 50 MHz
//  rst           in   1  reset, asynchronous, active-low
//  btn_raw       in   1  raw button pin, asynchronous to clk
//  btn_level     out  1  debounced level, 1 = pressed
//  press_pulse   out  1  1-cycle strobe on debounced press
//  release_pulse out  1  1-cycle strobe on debounced release
//  repeat_pulse  out  1  1-cycle strobe on each auto-repeat
//  key_pulse     out  1  press_pulse | repeat_pulse (use for "add")
//  long_hold     out  1  level, 1 while in REPEAT state
// BEHAVIOUR
//  Reset (rst=0, async): sync flops = released level, stable=0, all counters 0, FSM=IDLE, all outputs 0.
//  Sync: 2-flop synchroniser; polarity normalised after 2nd flop (pressed=1).
//  Debounce: cnt_db ($clog2(DEBOUNCE_CYCLES) bits). If sync==stable, cnt_db<=0.
//   Else if cnt_db==DEBOUNCE_CYCLES-1: stable<=sync, cnt_db<=0. Else cnt_db++.
//   Any glitch shorter than DEBOUNCE_CYCLES restarts count; no output change.
//  Latency: raw change -> btn_level/press_pulse/release_pulse = DEBOUNCE_CYCLES+3 clk edges (2 sync + DB + 1 reg).
//  FSM (one hold counter cnt_h, width $clog2(max(HOLD,REPEAT)); saturating never needed, always reloaded):
//   IDLE:    stable rises -> PRESSED, press_pulse=1, key_pulse=1, cnt_h<=0.
//   PRESSED: stable falls -> IDLE, release_pulse=1.
//            else cnt_h==HOLD_CYCLES-1 -> REPEAT, repeat_pulse=1, key_pulse=1, long_hold<=1, cnt_h<=0.
//            else cnt_h++.
//   REPEAT:  stable falls -> IDLE, release_pulse=1, long_hold<=0 same edge, no repeat that cycle.
//            else cnt_h==REPEAT_CYCLES-1 -> repeat_pulse=1, key_pulse=1, cnt_h<=0; else cnt_h++.
//  Release has priority over a coincident hold/repeat expiry. press_pulse and release_pulse never both 1.
//  Strobes are exactly 1 cycle; key_pulse spacing in REPEAT is exactly REPEAT_CYCLES.
//  Reset mid-operation: outputs drop immediately (async); if button still held after rst rises,
//   it is re-debounced and produces a fresh press_pulse DEBOUNCE_CYCLES+3 edges after rst deassert.
//  No release_pulse is generated by reset itself.
// TESTING  (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1; t=clk edges after raw change)
//  1 Glitch: btn_raw low 3 cycles then high -> no strobe, btn_level stays 0.
//  2 Short press: low 12 cycles -> press_pulse+key_pulse at t=7 only; release_pulse at t=7 after rising edge;
//    repeat_pulse never.
//  3 Hold 60 cycles: key_pulse at t=7,27,35,43,51,59; long_hold=1 from t=27; repeat_pulse at 27..59 only.
//  4 Bounce: toggle every 2 cycles for 20 cycles, then steady low -> exactly one press_pulse, 7 edges after last
//    toggle.
//  5 Release in REPEAT coincident with repeat expiry -> release_pulse=1, repeat_pulse=0, long_hold=0 that edge.
//  6 rst pulsed low at t=40 of a hold -> all outputs 0 asynchronously; button still low -> press_pulse 7 edges
//    after rst rises, no release_pulse.

Source files
------------

// File: rtl/key_repeat.sv
// ---------------------------------------------------------------------------
// key_repeat
//   Conditions one clock-setting push-button. The raw pin is synchronised,
//   debounced and turned into single-cycle clk-domain strobes: one on press,
//   periodic auto-repeat strobes while held, and one on release.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous reset, active-low
//   btn_raw       in   raw button pin, asynchronous to clk
//   btn_level     out  debounced level, 1 = pressed
//   press_pulse   out  1-cycle strobe on debounced press
//   release_pulse out  1-cycle strobe on debounced release
//   repeat_pulse  out  1-cycle strobe on each auto-repeat
//   key_pulse     out  press_pulse | repeat_pulse
//   long_hold     out  1 while auto-repeating
// ---------------------------------------------------------------------------
module key_repeat #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic key_pulse,
  output logic long_hold
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int H_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int H_W   = $clog2(H_MAX);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [H_W-1:0]  HOLD_LAST   = H_W'(HOLD_CYCLES - 1);
  localparam logic [H_W-1:0]  REPEAT_LAST = H_W'(REPEAT_CYCLES - 1);
  // Pin level that means "released"; the synchroniser resets to it so that
  // reset never looks like a press.
  localparam logic            PIN_IDLE    = ACTIVE_LOW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2
  } state_t;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic [DB_W-1:0] r_cnt_db;
  logic [H_W-1:0]  r_cnt_h;
  state_t          r_state;

  logic            w_sync_pressed;
  state_t          w_state_nxt;
  logic [H_W-1:0]  w_cnt_h_nxt;
  logic            w_press;
  logic            w_release;
  logic            w_repeat;

  // Polarity is normalised only after the second flop, so pressed = 1 here.
  assign w_sync_pressed = r_sync2 ^ ACTIVE_LOW;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= PIN_IDLE;
      r_sync2 <= PIN_IDLE;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: the stable level flips only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= 1'b0;
      r_cnt_db <= '0;
    end else if (w_sync_pressed == r_stable) begin
      r_cnt_db <= '0;
    end else if (r_cnt_db == DB_LAST) begin
      r_stable <= w_sync_pressed;
      r_cnt_db <= '0;
    end else begin
      r_cnt_db <= r_cnt_db + DB_W'(1);
    end
  end

  // Next-state and strobe decode; release is tested first so it wins over a
  // coincident hold/repeat expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_h_nxt = r_cnt_h;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_repeat    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_h_nxt = '0;
        if (r_stable) begin
          w_state_nxt = S_PRESSED;
          w_press     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRESSED: begin
        if (!r_stable) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
          w_cnt_h_nxt = '0;
        end else if (r_cnt_h == HOLD_LAST) begin
          w_state_nxt = S_REPEAT;
          w_repeat    = 1'b1;
          w_cnt_h_nxt = '0;
        end else begin
          w_cnt_h_nxt = r_cnt_h + H_W'(1);
        end
      end
      S_REPEAT: begin
        if (!r_stable) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
          w_cnt_h_nxt = '0;
        end else if (r_cnt_h == REPEAT_LAST) begin
          w_repeat    = 1'b1;
          w_cnt_h_nxt = '0;
        end else begin
          w_cnt_h_nxt = r_cnt_h + H_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_h_nxt = '0;
      end
    endcase
  end

  // State, hold counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt_h       <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      key_pulse     <= 1'b0;
      long_hold     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt_h       <= w_cnt_h_nxt;
      btn_level     <= r_stable;
      press_pulse   <= w_press;
      release_pulse <= w_release;
      repeat_pulse  <= w_repeat;
      key_pulse     <= w_press | w_repeat;
      long_hold     <= (w_state_nxt == S_REPEAT);
    end
  end

endmodule

// File: tb/tb_key_repeat.sv
module tb_key_repeat;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic btn_level, press_pulse, release_pulse, repeat_pulse, key_pulse, long_hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_repeat #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse),
    .key_pulse(key_pulse),
    .long_hold(long_hold)
  );

  // Output vector order: {level, press, release, repeat, key, long_hold}
  function automatic logic [5:0] outs();
    return {btn_level, press_pulse, release_pulse, repeat_pulse, key_pulse, long_hold};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lvl/prs/rel/rep/key/lh=%b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scenario: pin held low for low_len cycles, then released.
  // Expected event times (edges after the raw falling change); -1 = never.
  typedef struct {
    int low_len;
    int press_t;
    int release_t;
    int first_rep;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // Debounce 4 -> 7-edge latency; hold 20 -> first repeat at 27; repeat 8.
    vecs[0] = '{low_len: 3,  press_t: -1, release_t: -1, first_rep: -1}; // glitch
    vecs[1] = '{low_len: 12, press_t: 7,  release_t: 19, first_rep: -1}; // short press
    vecs[2] = '{low_len: 60, press_t: 7,  release_t: 67, first_rep: 27}; // long hold, release on repeat expiry
    vecs[3] = '{low_len: 28, press_t: 7,  release_t: 35, first_rep: 27}; // release on 1st repeat expiry
    vecs[4] = '{low_len: 34, press_t: 7,  release_t: 41, first_rep: 27}; // release mid repeat period

    rst = 1'b0;
    btn_raw = 1'b1;
    step();
    check("reset_state", 6'b000000);
    step();
    check("reset_hold", 6'b000000);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("idle_after_reset", 6'b000000);
    end

    // Table-driven scenarios, every output compared every cycle.
    for (int s = 0; s < 5; s++) begin
      int run;
      vec_t v;
      v = vecs[s];
      run = (v.release_t > 10) ? v.release_t + 4 : 14;
      btn_raw = 1'b0;
      for (int t = 1; t <= run; t++) begin
        logic e_lvl, e_prs, e_rel, e_rep, e_lh;
        step();
        if (t == v.low_len) btn_raw = 1'b1;
        e_prs = (t == v.press_t);
        e_rel = (t == v.release_t);
        e_lvl = (v.press_t >= 0) && (t >= v.press_t) && (t < v.release_t);
        e_lh  = (v.first_rep >= 0) && (t >= v.first_rep) && (t < v.release_t);
        e_rep = e_lh && (((t - v.first_rep) % 8) == 0);
        check($sformatf("vec%0d_t%0d", s, t), {e_lvl, e_prs, e_rel, e_rep, e_prs | e_rep, e_lh});
      end
      btn_raw = 1'b1;
      for (int i = 0; i < 10; i++) step();
    end

    // Bounce: toggle every 2 cycles for 20 cycles, then steady low.
    for (int i = 0; i < 20; i++) begin
      btn_raw = (((i / 2) % 2) == 0) ? 1'b0 : 1'b1;
      step();
      check($sformatf("bounce_i%0d", i), 6'b000000);
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      logic p;
      step();
      p = (k == 7);
      check($sformatf("bounce_settle_t%0d", k), {k >= 7, p, 1'b0, 1'b0, p, 1'b0});
    end
    btn_raw = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // Reset in the middle of a long hold.
    btn_raw = 1'b0;
    for (int t = 1; t <= 40; t++) step();
    check("hold_t40_before_rst", {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_clear", 6'b000000);
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_held", 6'b000000);
    end
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      logic p;
      step();
      p = (k == 7);
      check($sformatf("post_rst_t%0d", k), {k >= 7, p, 1'b0, 1'b0, p, 1'b0});
    end
    btn_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("post_rst_release_t%0d", k), {k < 7, 1'b0, k == 7, 1'b0, 1'b0, 1'b0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
